single_ifetch: RTL and testbench

Instruction-fetch sequencer for the single-cycle CPU: the consumer end of the PC-register interface. Latches the current PC, issues a request/acknowledge read to instruction memory (variable latency), and holds the returned instruction with a valid/ready handshake toward decode. Pulses a PC-advance strobe with the computed next PC, and handles redirects (branch/jump) mid-fetch. Sits between the PC register, instruction memory and decode.

---
 rtl/single_ifetch.sv | 174 +++++++++++++++++
 tb/tb_single_ifetch.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/single_ifetch.sv
// Instruction-fetch sequencer: PC latch, variable-latency imem read, decode handshake.
// Optional IFETCH_TIMEOUT_EN: faults when an imem read waits 255 cycles without ack.
module single_ifetch #(
   parameter logic [31:0] RESET_VEC = 32'h0000_0000,
   parameter logic [31:0] PC_STEP   = 32'd4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] i_pc,
   input  logic        i_mem_ack,
   input  logic [31:0] i_mem_rdata,
   input  logic        i_inst_ready,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc,
   output logic        o_mem_req,
   output logic [31:0] o_mem_addr,
   output logic [31:0] o_inst,
   output logic [31:0] o_inst_pc,
   output logic        o_inst_valid,
   output logic        o_pc_we,
   output logic [31:0] o_next_pc,
   output logic        o_fault
);

   typedef enum logic [2:0] {
      S_REQ,
      S_WAIT,
      S_VALID,
      S_DRAIN,
      S_FAULT
   } state_t;

   state_t      state;
   state_t      state_nx;
   logic [31:0] addr_q;
   logic        misal;
   logic        redir;
   logic        accept;
   logic        capture;
   logic        timeout;

   assign misal = addr_q[1:0] != 2'b00;

   // a misaligned address faults before any redirect can retarget it
   assign redir = i_redirect && state != S_FAULT
               && !(state == S_REQ && misal);

   assign accept = state == S_VALID && i_inst_ready && !i_redirect;

   assign capture = i_mem_ack && !i_redirect
                 && (state == S_WAIT || (state == S_REQ && !misal));

`ifdef IFETCH_TIMEOUT_EN
   logic [7:0] wait_cnt;

   // held at zero outside WAIT so every WAIT entry starts from 0
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         wait_cnt <= 8'd0;
      else if (state != S_WAIT)
         wait_cnt <= 8'd0;
      else
         wait_cnt <= wait_cnt + 8'd1;
   end

   assign timeout = wait_cnt == 8'hFE;
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= S_REQ;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_REQ: begin
            if (misal)
               state_nx = S_FAULT;
            else if (i_redirect)
               state_nx = S_REQ;
            else if (i_mem_ack)
               state_nx = S_VALID;
            else
               state_nx = S_WAIT;
         end
         S_WAIT: begin
            if (i_redirect)
               state_nx = i_mem_ack ? S_REQ : S_DRAIN;
            else if (i_mem_ack)
               state_nx = S_VALID;
            else if (timeout)
               state_nx = S_FAULT;
         end
         S_VALID: begin
            if (i_redirect || i_inst_ready)
               state_nx = S_REQ;
         end
         S_DRAIN: begin
            if (i_mem_ack)
               state_nx = S_REQ;
         end
         S_FAULT: state_nx = S_FAULT;
         default: state_nx = S_FAULT;
      endcase
   end

   always_comb begin
      o_mem_req  = 1'b0;
      o_fault    = 1'b0;
      o_mem_addr = addr_q;
      unique case (state)
         S_REQ: begin
            o_mem_req = !misal && !rst;
            o_fault   = misal;
         end
         S_WAIT:  o_mem_req = !rst;
         S_FAULT: o_fault   = 1'b1;
         default: o_mem_req = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q       <= RESET_VEC;
         o_inst       <= 32'd0;
         o_inst_pc    <= 32'd0;
         o_inst_valid <= 1'b0;
         o_pc_we      <= 1'b0;
         o_next_pc    <= 32'd0;
      end else begin
         o_pc_we <= 1'b0;
         if (redir) begin
            o_pc_we      <= 1'b1;
            o_next_pc    <= i_redirect_pc;
            addr_q       <= i_redirect_pc;
            o_inst_valid <= 1'b0;
         end else if (accept) begin
            o_pc_we      <= 1'b1;
            o_next_pc    <= o_inst_pc + PC_STEP;
            addr_q       <= o_inst_pc + PC_STEP;
            o_inst_valid <= 1'b0;
         end else if (capture) begin
            o_inst       <= i_mem_rdata;
            o_inst_pc    <= addr_q;
            o_inst_valid <= 1'b1;
         end
      end
   end

   // the PC register must hold the strobed value one cycle after the strobe
   logic        chk_q;
   logic [31:0] pc_exp;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chk_q  <= 1'b0;
         pc_exp <= RESET_VEC;
      end else begin
         chk_q <= o_pc_we;
         if (o_pc_we)
            pc_exp <= o_next_pc;
      end
   end

   a_pc_track: assert property (
      @(posedge clk) disable iff (rst) chk_q |-> i_pc == pc_exp
   );

endmodule

// File: tb/tb_single_ifetch.sv
// Directed testbench for single_ifetch.
// Drives a simple PC-register model onto i_pc.
module tb_single_ifetch;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] i_pc;
   logic        i_mem_ack;
   logic [31:0] i_mem_rdata;
   logic        i_inst_ready;
   logic        i_redirect;
   logic [31:0] i_redirect_pc;
   logic        o_mem_req;
   logic [31:0] o_mem_addr;
   logic [31:0] o_inst;
   logic [31:0] o_inst_pc;
   logic        o_inst_valid;
   logic        o_pc_we;
   logic [31:0] o_next_pc;
   logic        o_fault;

   int errs = 0;
   int checks = 0;

   always #5 clk = ~clk;

   single_ifetch dut (
      .clk(clk),
      .rst(rst),
      .i_pc(i_pc),
      .i_mem_ack(i_mem_ack),
      .i_mem_rdata(i_mem_rdata),
      .i_inst_ready(i_inst_ready),
      .i_redirect(i_redirect),
      .i_redirect_pc(i_redirect_pc),
      .o_mem_req(o_mem_req),
      .o_mem_addr(o_mem_addr),
      .o_inst(o_inst),
      .o_inst_pc(o_inst_pc),
      .o_inst_valid(o_inst_valid),
      .o_pc_we(o_pc_we),
      .o_next_pc(o_next_pc),
      .o_fault(o_fault)
   );

   // architectural PC register
   always @(posedge clk or posedge rst) begin
      if (rst)
         i_pc <= 32'd0;
      else if (o_pc_we)
         i_pc <= o_next_pc;
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset;
      rst = 1'b1;
      i_mem_ack = 1'b0;
      i_inst_ready = 1'b0;
      i_redirect = 1'b0;
      i_redirect_pc = 32'd0;
      i_mem_rdata = 32'd0;
      step();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      i_mem_ack = 1'b0;
      i_inst_ready = 1'b0;
      i_redirect = 1'b0;
      i_redirect_pc = 32'd0;
      i_mem_rdata = 32'd0;
      #2;
      checks++;
      if ({o_mem_req, o_inst_valid, o_pc_we, o_fault} !== 4'b0000) begin
         errs++;
         $display("FAIL reset_ctl got %b want 0000",
                  {o_mem_req, o_inst_valid, o_pc_we, o_fault});
      end
      checks++;
      if ({o_mem_addr, o_inst, o_inst_pc, o_next_pc} !== 128'd0) begin
         errs++;
         $display("FAIL reset_data addr=%h inst=%h ipc=%h npc=%h want 0",
                  o_mem_addr, o_inst, o_inst_pc, o_next_pc);
      end
      step();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_basic;
      apply_reset();
      checks++;
      if (o_mem_req !== 1'b1 || o_mem_addr !== 32'h0) begin
         errs++;
         $display("FAIL basic_req got req=%b addr=%h want 1/0", o_mem_req, o_mem_addr);
      end
      step();
      i_mem_ack = 1'b1;
      i_mem_rdata = 32'h2002_0005;
      i_inst_ready = 1'b1;
      step();
      i_mem_ack = 1'b0;
      checks++;
      if (o_inst_valid !== 1'b1 || o_inst !== 32'h2002_0005 || o_inst_pc !== 32'h0) begin
         errs++;
         $display("FAIL basic_valid got v=%b inst=%h pc=%h want 1/20020005/0",
                  o_inst_valid, o_inst, o_inst_pc);
      end
      step();
      i_inst_ready = 1'b0;
      checks++;
      if (o_pc_we !== 1'b1 || o_next_pc !== 32'h4 || o_mem_addr !== 32'h4
          || o_mem_req !== 1'b1 || o_inst_valid !== 1'b0) begin
         errs++;
         $display("FAIL basic_adv got we=%b npc=%h addr=%h req=%b v=%b want 1/4/4/1/0",
                  o_pc_we, o_next_pc, o_mem_addr, o_mem_req, o_inst_valid);
      end
      step();
      checks++;
      if (o_pc_we !== 1'b0) begin
         errs++;
         $display("FAIL basic_pulse got we=%b want 0", o_pc_we);
      end
   endtask

   task automatic test_latency;
      int reqs = 0;
      int pulses = 0;
      apply_reset();
      for (int i = 0; i < 5; i++) begin
         if (o_mem_req === 1'b1)
            reqs++;
         if (i == 4) begin
            i_mem_ack = 1'b1;
            i_mem_rdata = 32'h0123_4567;
         end
         step();
      end
      i_mem_ack = 1'b0;
      checks++;
      if (reqs !== 5 || o_mem_req !== 1'b0) begin
         errs++;
         $display("FAIL lat_req got reqs=%0d req=%b want 5/0", reqs, o_mem_req);
      end
      for (int i = 0; i < 3; i++) begin
         if (o_pc_we === 1'b1)
            pulses++;
         checks++;
         if (o_inst_valid !== 1'b1 || o_inst !== 32'h0123_4567) begin
            errs++;
            $display("FAIL lat_hold%0d got v=%b inst=%h want 1/01234567",
                     i, o_inst_valid, o_inst);
         end
         step();
      end
      i_inst_ready = 1'b1;
      step();
      i_inst_ready = 1'b0;
      if (o_pc_we === 1'b1)
         pulses++;
      step();
      if (o_pc_we === 1'b1)
         pulses++;
      checks++;
      if (pulses !== 1 || o_next_pc !== 32'h4) begin
         errs++;
         $display("FAIL lat_pulse got pulses=%0d npc=%h want 1/4", pulses, o_next_pc);
      end
   endtask

   task automatic test_redirect_wait;
      int seen = 0;
      apply_reset();
      step();
      i_redirect = 1'b1;
      i_redirect_pc = 32'h40;
      step();
      i_redirect = 1'b0;
      checks++;
      if (o_pc_we !== 1'b1 || o_next_pc !== 32'h40 || o_mem_req !== 1'b0) begin
         errs++;
         $display("FAIL rw_strobe got we=%b npc=%h req=%b want 1/40/0",
                  o_pc_we, o_next_pc, o_mem_req);
      end
      step();
      i_mem_ack = 1'b1;
      i_mem_rdata = 32'hDEAD_BEEF;
      step();
      i_mem_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (o_inst_valid === 1'b1)
            seen++;
         if (i == 0) begin
            checks++;
            if (o_mem_req !== 1'b1 || o_mem_addr !== 32'h40) begin
               errs++;
               $display("FAIL rw_refetch got req=%b addr=%h want 1/40",
                        o_mem_req, o_mem_addr);
            end
         end
         step();
      end
      checks++;
      if (seen !== 0) begin
         errs++;
         $display("FAIL rw_discard got valid_cycles=%0d want 0", seen);
      end
   endtask

   task automatic test_redirect_priority;
      apply_reset();
      i_redirect = 1'b1;
      i_redirect_pc = 32'h8;
      step();
      i_redirect = 1'b0;
      step();
      i_mem_ack = 1'b1;
      i_mem_rdata = 32'h0000_0013;
      step();
      i_mem_ack = 1'b0;
      checks++;
      if (o_inst_valid !== 1'b1 || o_inst_pc !== 32'h8) begin
         errs++;
         $display("FAIL rp_valid got v=%b pc=%h want 1/8", o_inst_valid, o_inst_pc);
      end
      i_inst_ready = 1'b1;
      i_redirect = 1'b1;
      i_redirect_pc = 32'h100;
      step();
      i_inst_ready = 1'b0;
      i_redirect = 1'b0;
      checks++;
      if (o_pc_we !== 1'b1 || o_next_pc !== 32'h100 || o_mem_addr !== 32'h100
          || o_inst_valid !== 1'b0) begin
         errs++;
         $display("FAIL rp_target got we=%b npc=%h addr=%h v=%b want 1/100/100/0",
                  o_pc_we, o_next_pc, o_mem_addr, o_inst_valid);
      end
   endtask

   task automatic test_wrap_fast_ack;
      apply_reset();
      i_redirect = 1'b1;
      i_redirect_pc = 32'hFFFF_FFFC;
      step();
      i_redirect = 1'b0;
      i_mem_ack = 1'b1;
      i_mem_rdata = 32'hCAFE_F00D;
      step();
      i_mem_ack = 1'b0;
      checks++;
      if (o_inst_valid !== 1'b1 || o_inst_pc !== 32'hFFFF_FFFC || o_inst !== 32'hCAFE_F00D) begin
         errs++;
         $display("FAIL wrap_fast got v=%b pc=%h inst=%h want 1/fffffffc/cafef00d",
                  o_inst_valid, o_inst_pc, o_inst);
      end
      i_inst_ready = 1'b1;
      step();
      i_inst_ready = 1'b0;
      checks++;
      if (o_pc_we !== 1'b1 || o_next_pc !== 32'h0 || o_mem_addr !== 32'h0) begin
         errs++;
         $display("FAIL wrap_next got we=%b npc=%h addr=%h want 1/0/0",
                  o_pc_we, o_next_pc, o_mem_addr);
      end
   endtask

   task automatic test_fault;
      int bad = 0;
      apply_reset();
      i_redirect = 1'b1;
      i_redirect_pc = 32'h102;
      step();
      i_redirect = 1'b0;
      checks++;
      if (o_fault !== 1'b1 || o_mem_req !== 1'b0) begin
         errs++;
         $display("FAIL fault_rise got fault=%b req=%b want 1/0", o_fault, o_mem_req);
      end
      step();
      for (int i = 0; i < 6; i++) begin
         i_redirect = (i == 2);
         i_redirect_pc = 32'h200;
         i_mem_ack = (i == 3);
         if (o_fault !== 1'b1 || o_mem_req !== 1'b0 || o_inst_valid !== 1'b0
             || o_pc_we !== 1'b0)
            bad++;
         step();
      end
      i_redirect = 1'b0;
      i_mem_ack = 1'b0;
      checks++;
      if (bad !== 0) begin
         errs++;
         $display("FAIL fault_sticky got bad_cycles=%0d want 0", bad);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (o_fault !== 1'b0 || o_mem_addr !== 32'h0) begin
         errs++;
         $display("FAIL fault_clear got fault=%b addr=%h want 0/0", o_fault, o_mem_addr);
      end
      step();
      rst = 1'b0;
      i_redirect = 1'b1;
      i_redirect_pc = 32'h20;
      step();
      i_redirect = 1'b0;
      step();
      checks++;
      if (o_mem_req !== 1'b1 || o_mem_addr !== 32'h20 || o_next_pc !== 32'h20) begin
         errs++;
         $display("FAIL arst_pre got req=%b addr=%h npc=%h want 1/20/20",
                  o_mem_req, o_mem_addr, o_next_pc);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({o_mem_req, o_inst_valid, o_pc_we, o_fault} !== 4'b0000
          || o_mem_addr !== 32'h0 || o_next_pc !== 32'h0) begin
         errs++;
         $display("FAIL arst_mid got ctl=%b addr=%h npc=%h want 0000/0/0",
                  {o_mem_req, o_inst_valid, o_pc_we, o_fault}, o_mem_addr, o_next_pc);
      end
      step();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_timeout;
      apply_reset();
      step();
`ifdef IFETCH_TIMEOUT_EN
      begin
         int n = -1;
         for (int i = 0; i < 300; i++) begin
            if (o_fault === 1'b1) begin
               n = i;
               break;
            end
            step();
         end
         checks++;
         if (n !== 255 || o_mem_req !== 1'b0) begin
            errs++;
            $display("FAIL timeout got cycles=%0d req=%b want 255/0", n, o_mem_req);
         end
      end
`else
      repeat (1000) step();
      checks++;
      if (o_mem_req !== 1'b1 || o_fault !== 1'b0) begin
         errs++;
         $display("FAIL no_timeout got req=%b fault=%b want 1/0", o_mem_req, o_fault);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_basic();
      test_latency();
      test_redirect_wait();
      test_redirect_priority();
      test_wrap_fast_ack();
      test_fault();
      test_timeout();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
